// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight and feeds IF/ID.
// Optional misaligned-redirect trap selected by FETCH_MISALIGN_CHECK_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        stall_if,
  input  logic        ex_if_branch_taken,
  input  logic [31:0] ex_if_branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr_data,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        fetch_misaligned
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic [XLEN-1:0]   hold_instr_q, hold_instr_d;
  logic [XLEN-1:0]   hold_pc_q, hold_pc_d;
  logic              kill_q, kill_d;
  logic [XLEN-1:0]   if_instr_q, if_instr_d;
  logic [XLEN-1:0]   if_pc_q, if_pc_d;
  logic              if_valid_q, if_valid_d;
  logic              misaligned_q, misaligned_d;

  logic              redirect;
  logic [XLEN-1:0]   target;
  logic              bad_target;
  logic              resp;
  logic              deliver;
  logic              hold_rel;
  logic              issue;
  logic              accept;

  // Redirect target handling depends on whether misaligned targets trap
`ifdef FETCH_MISALIGN_CHECK_EN
  assign target     = ex_if_branch_target;
  assign bad_target = ex_if_branch_taken && (ex_if_branch_target[1:0] != 2'b00);
`else
  assign target     = ex_if_branch_target & ~XLEN'(3);
  assign bad_target = 1'b0;
`endif

  assign redirect = ex_if_branch_taken;
  assign resp     = (state_q == S_WAIT) && imem_rvalid;
  assign deliver  = resp && !kill_q && !stall && !stall_if && !redirect;
  assign hold_rel = (state_q == S_HOLD) && !stall && !stall_if && !redirect;
  assign issue    = ((state_q == S_FETCH) || deliver) && !stall_if && !redirect && !misaligned_q;
  assign accept   = issue && imem_ready;

  // State register and datapath flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= '0;
      kill_q       <= 1'b0;
      if_instr_q   <= NOP_INSTR;
      if_pc_q      <= '0;
      if_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      kill_q       <= kill_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      if_valid_q   <= if_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: if (accept) state_d = S_WAIT;
      S_WAIT: begin
        if (resp) begin
          if (kill_q || redirect) state_d = S_FETCH;
          else if (deliver)       state_d = accept ? S_WAIT : S_FETCH;
          else                    state_d = S_HOLD;
        end
      end
      S_HOLD: if (redirect || hold_rel) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Datapath next values: PC, skid buffer, kill flag and IF/ID
  always_comb begin
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    kill_d       = kill_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    if_valid_d   = if_valid_q;
    misaligned_d = misaligned_q | bad_target;

    if (redirect)    pc_d = target;
    else if (accept) pc_d = pc_q + XLEN'(4);

    if (accept) req_pc_d = pc_q;

    if (resp && !kill_q && !redirect && !deliver) begin
      hold_instr_d = imem_rdata;
      hold_pc_d    = req_pc_q;
    end

    // A redirect with no response this cycle leaves a stale word in flight
    if (redirect && (state_q == S_WAIT) && !imem_rvalid) kill_d = 1'b1;
    else if (resp && kill_q)                             kill_d = 1'b0;

    if (redirect) begin
      if_instr_d = NOP_INSTR;
      if_valid_d = 1'b0;
    end else if (!stall) begin
      if (deliver) begin
        if_instr_d = imem_rdata;
        if_pc_d    = req_pc_q;
        if_valid_d = 1'b1;
      end else if (hold_rel) begin
        if_instr_d = hold_instr_q;
        if_pc_d    = hold_pc_q;
        if_valid_d = 1'b1;
      end else begin
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
      end
    end
  end

  // Output logic; request is suppressed while reset is asserted
  always_comb begin
    imem_req  = issue && rst;
    imem_addr = pc_q;
  end

  assign if_id_instr_data = if_instr_q;
  assign if_id_pc         = if_pc_q;
  assign if_id_valid      = if_valid_q;
  assign fetch_misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic against a program-order model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, stall_if = 1'b0, br = 1'b0;
  logic [31:0] tgt = '0;
  logic        imem_req, imem_ready = 1'b1, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [31:0] if_id_instr_data, if_id_pc;
  logic        if_id_valid, fetch_misaligned;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .stall_if(stall_if),
    .ex_if_branch_taken(br), .ex_if_branch_target(tgt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_instr_data(if_id_instr_data), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0;
  int          lat = 1;
  logic [31:0] key = '0;
  logic        stray = 1'b0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic        p_req, p_acc, p_rv, overlap;
  logic [31:0] p_addr;
  logic [31:0] prev_instr, prev_pc;
  logic        prev_valid;

  // One clock: memory model drives the response, pre-edge request is sampled, then the edge.
  task automatic step();
    @(negedge clk);
    prev_instr = if_id_instr_data;
    prev_pc    = if_id_pc;
    prev_valid = if_id_valid;
    if (stray) begin
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    end else if (pend && pend_cnt == 1) begin
      imem_rvalid = 1'b1; imem_rdata = pend_addr ^ key;
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    #1;
    p_req   = imem_req;
    p_addr  = imem_addr;
    p_rv    = imem_rvalid && !stray;
    p_acc   = imem_req && imem_ready;
    overlap = p_acc && pend && !p_rv;
    @(posedge clk);
    #1;
    if (p_rv) pend = 1'b0;
    else if (pend) pend_cnt--;
    if (p_acc) begin
      pend = 1'b1; pend_cnt = lat; pend_addr = p_addr;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = 1'b0; stall_if = 1'b0; br = 1'b0; tgt = '0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; pend = 1'b0; stray = 1'b0; key = '0; lat = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({imem_req, if_id_valid, fetch_misaligned} !== 3'b000 || if_id_instr_data !== NOP || if_id_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state: req=%b valid=%b mis=%b instr=%h pc=%h want 0,0,0,%h,0",
               imem_req, if_id_valid, fetch_misaligned, if_id_instr_data, if_id_pc, NOP);
    end
    rst = 1'b1; imem_ready = 1'b0; stray = 1'b1;
    step();
    stray = 1'b0;
    n_cmp++;
    if (if_id_valid !== 1'b0 || p_req !== 1'b1 || p_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_stray_rvalid: valid=%b req=%b addr=%h want 0,1,0", if_id_valid, p_req, p_addr);
    end
    imem_ready = 1'b1; lat = 1;
    repeat (3) step();
    n_cmp++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h4) begin
      n_bad++;
      $display("FAIL reset_pre_run: valid=%b pc=%h want 1,4", if_id_valid, if_id_pc);
    end
    // Reset again with the 0x8 response still in flight
    rst = 1'b0;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_pc !== 32'h0 || if_id_instr_data !== NOP) begin
      n_bad++;
      $display("FAIL reset_async: req=%b valid=%b pc=%h instr=%h want 0,0,0,%h",
               imem_req, if_id_valid, if_id_pc, if_id_instr_data, NOP);
    end
    pend = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    imem_ready = 1'b0; stray = 1'b1;
    step();
    stray = 1'b0;
    n_cmp++;
    if (if_id_valid !== 1'b0 || p_req !== 1'b1 || p_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_midtx_drop: valid=%b req=%b addr=%h want 0,1,0", if_id_valid, p_req, p_addr);
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    step();
    n_cmp++;
    if (p_req !== 1'b1 || p_addr !== 32'h0 || if_id_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL zw_first_req: req=%b addr=%h valid=%b want 1,0,0", p_req, p_addr, if_id_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * i) || if_id_instr_data !== 32'(4 * i)) begin
        n_bad++;
        $display("FAIL zw_stream%0d: valid=%b pc=%h instr=%h want 1,%h,%h",
                 i, if_id_valid, if_id_pc, if_id_instr_data, 32'(4 * i), 32'(4 * i));
      end
    end
  endtask

  task automatic test_ready_low();
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (p_req !== 1'b1 || p_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr_data !== NOP) begin
        n_bad++;
        $display("FAIL rdy_low%0d: req=%b addr=%h valid=%b instr=%h want 1,0,0,%h",
                 i, p_req, p_addr, if_id_valid, if_id_instr_data, NOP);
      end
    end
    imem_ready = 1'b1;
    step();
    step();
    n_cmp++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_instr_data !== 32'h0) begin
      n_bad++;
      $display("FAIL rdy_deliver: valid=%b pc=%h instr=%h want 1,0,0", if_id_valid, if_id_pc, if_id_instr_data);
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    repeat (3) step();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (p_req !== 1'b0 || if_id_valid !== 1'b1 || if_id_pc !== 32'h4) begin
        n_bad++;
        $display("FAIL stall_hold%0d: req=%b valid=%b pc=%h want 0,1,4", i, p_req, if_id_valid, if_id_pc);
      end
    end
    stall = 1'b0;
    step();
    n_cmp++;
    if (p_req !== 1'b0 || if_id_valid !== 1'b1 || if_id_pc !== 32'h8 || if_id_instr_data !== 32'h8) begin
      n_bad++;
      $display("FAIL stall_release: req=%b valid=%b pc=%h instr=%h want 0,1,8,8",
               p_req, if_id_valid, if_id_pc, if_id_instr_data);
    end
    step();
    n_cmp++;
    if (p_req !== 1'b1 || p_addr !== 32'hC || if_id_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_refetch: req=%b addr=%h valid=%b want 1,c,0", p_req, p_addr, if_id_valid);
    end
    step();
    n_cmp++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'hC) begin
      n_bad++;
      $display("FAIL stall_next: valid=%b pc=%h want 1,c", if_id_valid, if_id_pc);
    end
  endtask

  task automatic test_stall_if_redirect();
    logic seen;
    do_reset();
    lat = 2;
    repeat (7) step();
    n_cmp++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8) begin
      n_bad++;
      $display("FAIL sif_setup: valid=%b pc=%h want 1,8", if_id_valid, if_id_pc);
    end
    stall_if = 1'b1;
    step();
    stall_if = 1'b0;
    n_cmp++;
    if (p_req !== 1'b0 || if_id_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL sif_block: req=%b valid=%b want 0,0", p_req, if_id_valid);
    end
    br = 1'b1; tgt = 32'h100;
    step();
    br = 1'b0;
    n_cmp++;
    if (p_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr_data !== NOP) begin
      n_bad++;
      $display("FAIL sif_redirect_flush: req=%b valid=%b instr=%h want 0,0,%h", p_req, if_id_valid, if_id_instr_data, NOP);
    end
    step();
    n_cmp++;
    if (p_req !== 1'b1 || p_addr !== 32'h100) begin
      n_bad++;
      $display("FAIL sif_target_req: req=%b addr=%h want 1,100", p_req, p_addr);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = if_id_valid;
    end
    n_cmp++;
    if (!seen || if_id_pc !== 32'h100 || if_id_instr_data !== 32'h100) begin
      n_bad++;
      $display("FAIL sif_next_pc: seen=%b pc=%h instr=%h want 1,100,100", seen, if_id_pc, if_id_instr_data);
    end
  endtask

  task automatic test_kill();
    do_reset();
    lat = 2;
    step();
    br = 1'b1; tgt = 32'h40;
    step();
    br = 1'b0;
    step();
    n_cmp++;
    if (p_rv !== 1'b1 || p_req !== 1'b0 || if_id_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL kill_discard: rv=%b req=%b valid=%b want 1,0,0", p_rv, p_req, if_id_valid);
    end
    step();
    n_cmp++;
    if (p_req !== 1'b1 || p_addr !== 32'h40 || if_id_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL kill_target_req: req=%b addr=%h valid=%b want 1,40,0", p_req, p_addr, if_id_valid);
    end
    step();
    n_cmp++;
    if (if_id_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL kill_bubble: valid=%b want 0", if_id_valid);
    end
    step();
    n_cmp++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h40 || if_id_instr_data !== 32'h40) begin
      n_bad++;
      $display("FAIL kill_deliver: valid=%b pc=%h instr=%h want 1,40,40", if_id_valid, if_id_pc, if_id_instr_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    do_reset();
    repeat (2) step();
    br = 1'b1; tgt = 32'hFFFF_FFF8;
    step();
    br = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      exp = 32'hFFFF_FFF8 + 32'(4 * k);
      n_cmp++;
      if (if_id_valid !== 1'b1 || if_id_pc !== exp || if_id_instr_data !== exp) begin
        n_bad++;
        $display("FAIL b2b_wrap%0d: valid=%b pc=%h instr=%h want 1,%h,%h", k, if_id_valid, if_id_pc, if_id_instr_data, exp, exp);
      end
    end
  endtask

  task automatic test_misalign();
    do_reset();
    repeat (2) step();
    br = 1'b1; tgt = 32'h102;
    step();
    br = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    n_cmp++;
    if (fetch_misaligned !== 1'b1 || if_id_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mis_flag: mis=%b valid=%b want 1,0", fetch_misaligned, if_id_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (p_req !== 1'b0 || if_id_valid !== 1'b0 || fetch_misaligned !== 1'b1) begin
        n_bad++;
        $display("FAIL mis_halt%0d: req=%b valid=%b mis=%b want 0,0,1", i, p_req, if_id_valid, fetch_misaligned);
      end
    end
`else
    n_cmp++;
    if (fetch_misaligned !== 1'b0) begin
      n_bad++;
      $display("FAIL mis_tied: mis=%b want 0", fetch_misaligned);
    end
    step();
    n_cmp++;
    if (p_req !== 1'b1 || p_addr !== 32'h100) begin
      n_bad++;
      $display("FAIL mis_align_req: req=%b addr=%h want 1,100", p_req, p_addr);
    end
    step();
    n_cmp++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100) begin
      n_bad++;
      $display("FAIL mis_align_deliver: valid=%b pc=%h want 1,100", if_id_valid, if_id_pc);
    end
`endif
  endtask

  // Random traffic: delivered stream must follow program order from the latest redirect.
  task automatic test_random();
    logic [31:0] exp_dpc, exp_ipc;
    int          delivered;
    do_reset();
    key = $urandom;
    exp_dpc = 32'h0; exp_ipc = 32'h0; delivered = 0;
    for (int c = 0; c < 2000; c++) begin
      stall      = ($urandom % 4) == 0;
      stall_if   = ($urandom % 7) == 0;
      br         = ($urandom % 20) == 0;
      tgt        = $urandom & 32'hFFFF_FFFC;
      imem_ready = ($urandom % 10) < 7;
      lat        = 1 + int'($urandom % 3);
      step();
      n_cmp++;
      if (overlap || (p_req && (br || stall_if)) || (p_req && p_addr !== exp_ipc)) begin
        n_bad++;
        $display("FAIL rnd_issue c%0d: req=%b addr=%h overlap=%b br=%b sif=%b want addr %h",
                 c, p_req, p_addr, overlap, br, stall_if, exp_ipc);
      end
      if (p_acc) exp_ipc = exp_ipc + 32'h4;
      n_cmp++;
      if (br || (!stall && stall_if)) begin
        if (if_id_valid !== 1'b0 || if_id_instr_data !== NOP || if_id_pc !== prev_pc) begin
          n_bad++;
          $display("FAIL rnd_bubble c%0d: valid=%b instr=%h pc=%h want 0,%h,%h",
                   c, if_id_valid, if_id_instr_data, if_id_pc, NOP, prev_pc);
        end
      end else if (stall) begin
        if (if_id_valid !== prev_valid || if_id_instr_data !== prev_instr || if_id_pc !== prev_pc) begin
          n_bad++;
          $display("FAIL rnd_hold c%0d: valid=%b instr=%h pc=%h want %b,%h,%h",
                   c, if_id_valid, if_id_instr_data, if_id_pc, prev_valid, prev_instr, prev_pc);
        end
      end else if (if_id_valid === 1'b1) begin
        if (if_id_pc !== exp_dpc || if_id_instr_data !== (exp_dpc ^ key)) begin
          n_bad++;
          $display("FAIL rnd_deliver c%0d: pc=%h instr=%h want %h,%h",
                   c, if_id_pc, if_id_instr_data, exp_dpc, exp_dpc ^ key);
        end
        exp_dpc = exp_dpc + 32'h4;
        delivered++;
      end else if (if_id_valid !== 1'b0 || if_id_instr_data !== NOP || if_id_pc !== prev_pc) begin
        n_bad++;
        $display("FAIL rnd_idle c%0d: valid=%b instr=%h pc=%h want 0,%h,%h",
                 c, if_id_valid, if_id_instr_data, if_id_pc, NOP, prev_pc);
      end
      if (br) begin
        exp_dpc = tgt; exp_ipc = tgt;
      end
    end
    n_cmp++;
    if (delivered < 100) begin
      n_bad++;
      $display("FAIL rnd_progress: delivered=%0d want >= 100", delivered);
    end
    stall = 1'b0; stall_if = 1'b0; br = 1'b0; imem_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_ready_low();
    test_stall_hold();
    test_stall_if_redirect();
    test_kill();
    test_back_to_back();
    test_misalign();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage. Sits directly upstream of the decode stage.
- Owns the PC and issues requests to instruction memory with at most one request outstanding.
- Feeds the IF/ID pipeline registers (instruction word and PC). Inserts NOP bubbles on decode hold-off, redirect and memory latency.
- Takes taken-branch/jump redirects from the execute stage and flushes wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven into IF/ID.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- stall  in  1  global pipeline stall; freezes IF/ID registers.
- stall_if  in  1  from decode: control-flow instruction in ID; no new fetch delivered or issued.
- ex_if_branch_taken  in  1  redirect request from execute, single-cycle pulse.
- ex_if_branch_target  in  32  redirect address.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; word aligned.
- imem_ready  in  1  memory accepts request when imem_req && imem_ready.
- imem_rvalid  in  1  response valid; at least 1 cycle after acceptance.
- imem_rdata  in  32  response instruction word.
- if_id_instr_data  out  32  instruction to decode.
- if_id_pc  out  32  PC of if_id_instr_data.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.
- fetch_misaligned  out  1  sticky misaligned-redirect flag (see Optional Feature).

Behaviour:
- Registers:
  - pc: next address to request.
  - req_pc: address of the outstanding request.
  - hold_instr / hold_pc: one-entry skid buffer.
  - kill: set when an outstanding response must be discarded.
  - state: FETCH, WAIT or HOLD.
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=FETCH, kill=0.
  - if_id_instr_data=NOP_INSTR, if_id_pc=0, if_id_valid=0.
  - imem_req=0, fetch_misaligned=0.
  - Reset mid-transaction drops the outstanding response; any rvalid in the first cycle after release is ignored.
- Issue condition:
  - imem_req = (state==FETCH || (state==WAIT && deliver)) && !stall_if && !redirect.
  - imem_addr = pc.
  - On acceptance: req_pc<=pc, pc<=pc+4 (32-bit wrap 0xFFFF_FFFC -> 0), state<=WAIT.
- Response handling in WAIT, on imem_rvalid:
  - kill=1: discard data, clear kill, state<=FETCH.
  - Else if !stall && !stall_if: deliver (IF/ID <= rdata, req_pc, valid=1). Next state is WAIT if a new request was accepted the same cycle, else FETCH.
  - Else: capture into hold buffer, state<=HOLD, no request issued.
- HOLD:
  - When !stall && !stall_if: deliver the held word, state<=FETCH.
  - Next request is issued the following cycle.
- IF/ID update when !stall and nothing delivered: load NOP_INSTR, valid=0, if_id_pc unchanged.
- When stall=1 and no redirect: IF/ID hold their values.
- Redirect (ex_if_branch_taken=1) has highest priority, independent of stall:
  - pc<=target; IF/ID <= NOP_INSTR, valid=0; no request that cycle.
  - WAIT without same-cycle rvalid: kill<=1.
  - WAIT with same-cycle rvalid: drop data, state<=FETCH.
  - HOLD: drop buffer, state<=FETCH.
  - Next cycle in FETCH: imem_req with imem_addr=target.
- Latency and throughput: with zero-wait memory (ready=1, rvalid 1 cycle after acceptance), the first instruction reaches IF/ID 2 edges after reset release, then 1 instruction per cycle.
- Never more than one outstanding request. imem_req never asserted while in WAIT without a same-cycle rvalid, or while in HOLD.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Redirect with target[1:0]!=0 sets fetch_misaligned=1 (sticky until reset).
  - IF/ID is flushed and fetching halts: imem_req stays 0.
- Undefined:
  - target[1:0] forced to 2'b00.
  - fetch_misaligned tied to 0.

Test Plan:
- Release reset with zero-wait memory returning addr as data -> first req addr 0x0; IF/ID sees 0x0,0x4,0x8 on consecutive cycles with valid=1.
- imem_ready low 3 cycles after first request -> imem_addr held at 0x0, IF/ID gets NOP (valid=0) until the response, then instr at pc 0x0.
- stall=1 for 2 cycles while response for 0x8 arrives -> word held in HOLD; delivered with pc 0x8 the cycle after stall drops; no duplicate, no loss.
- stall_if=1 one cycle, then ex_if_branch_taken with target 0x100 while the 0xC response is in flight -> 0xC word discarded; next delivered instruction pc 0x100.
- Redirect to 0x40 while in WAIT with 2-cycle memory latency -> late response killed; next imem_addr 0x40; if_id_valid=0 until the 0x40 word arrives.
- With FETCH_MISALIGN_CHECK_EN: redirect to 0x102 -> fetch_misaligned=1, imem_req=0 thereafter. Without macro: fetch from 0x100.
